// File: rtl/cart_pkg.sv
// Shared types and constants for the cart memory path.
//   arb_state_e : arbiter FSM states
//   arb_src_e   : which requester owns the current memory transaction
//   BYTE_FILL   : data returned when a memory transaction is abandoned
package cart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_BUS,
        SRC_DL,
        SRC_SV
    } arb_src_e;

    localparam logic [7:0] BYTE_FILL = 8'hFF;

endpackage

// File: rtl/cart_rd_cache.sv
// One-entry read cache for cart bus reads.
// Ports:
//   clk_sys, reset   : system clock, synchronous active-high reset
//   lookup_addr      : address compared against the stored tag
//   hit, hit_data    : combinational hit flag and cached byte
//   load, load_addr, load_data : write a new tag/data and mark valid
//   inv, inv_addr    : drop the entry if inv_addr matches the tag
module cart_rd_cache #(
    parameter int unsigned ADDR_W = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [7:0]        hit_data,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              inv,
    input  logic [ADDR_W-1:0] inv_addr
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [7:0]        data_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            tag_q   <= load_addr;
            data_q  <= load_data;
        end else if (inv && (inv_addr == tag_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit      = valid_q && (lookup_addr == tag_q);
    assign hit_data = data_q;

endmodule

// File: rtl/cart_mem_arbiter.sv
// Arbitrates the external cart memory port between cart bus reads, ROM download
// writes and save-device traffic (fixed priority bus > dl > sv), with a
// one-entry read cache in front of the bus path.
// Ports:
//   clk_sys, reset                 : system clock, synchronous active-high reset
//   bus_req/bus_addr               : cart read request pulse and address
//   bus_data/bus_valid             : read data and 1-cycle completion pulse
//   dl_wr/dl_addr/dl_data/dl_wait  : loader write pulse, payload, back-pressure
//   sv_req/sv_we/sv_addr/sv_din    : save-device request pulse and payload
//   sv_dout/sv_ack                 : save read data and completion pulse
//   mem_req/mem_we/mem_addr/mem_din: memory request, held until mem_ack
//   mem_dout/mem_ack               : memory read data and completion pulse
module cart_mem_arbiter
    import cart_pkg::*;
#(
    parameter int unsigned ADDR_W  = 25,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bus_req,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_data,
    output logic              bus_valid,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    input  logic              sv_req,
    input  logic              sv_we,
    input  logic [ADDR_W-1:0] sv_addr,
    input  logic [7:0]        sv_din,
    output logic [7:0]        sv_dout,
    output logic              sv_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    // Leaving WAIT when the counter would step onto TIMEOUT keeps mem_req high
    // for exactly TIMEOUT+1 cycles (ISSUE plus TIMEOUT WAIT cycles).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    arb_state_e        state_q, state_d;
    arb_src_e          src_q, src_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              bus_pend_q, bus_pend_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              dl_pend_q, dl_pend_d;
    logic [ADDR_W-1:0] dl_addr_q, dl_addr_d;
    logic [7:0]        dl_data_q, dl_data_d;
    logic              sv_pend_q, sv_pend_d;
    logic              sv_we_q, sv_we_d;
    logic [ADDR_W-1:0] sv_addr_q, sv_addr_d;
    logic [7:0]        sv_din_q, sv_din_d;

    logic              cur_we_q, cur_we_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [7:0]        cur_din_q, cur_din_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              timed_out_q, timed_out_d;
    logic              bus_stale_q, bus_stale_d;

    logic              bus_valid_q, bus_valid_d;
    logic [7:0]        bus_data_q, bus_data_d;
    logic              sv_ack_q, sv_ack_d;
    logic [7:0]        sv_dout_q, sv_dout_d;

    logic              cache_hit;
    logic [7:0]        cache_data;
    logic              cache_load;
    logic              cache_inv;
    logic              wait_exit;
    logic [7:0]        exit_data;
    logic              bus_inflight;

    cart_rd_cache #(
        .ADDR_W (ADDR_W)
    ) u_cache (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .lookup_addr (bus_addr),
        .hit         (cache_hit),
        .hit_data    (cache_data),
        .load        (cache_load),
        .load_addr   (cur_addr_q),
        .load_data   (rd_data_q),
        .inv         (cache_inv),
        .inv_addr    (cur_addr_q)
    );

    assign wait_exit = (state_q == ARB_WAIT) && (mem_ack || (cnt_q == CNT_LAST));
    assign exit_data = mem_ack ? mem_dout : BYTE_FILL;

    // A bus read is committed from the moment IDLE picks it until WAIT exits;
    // a new bus_req in that window makes its result obsolete.
    assign bus_inflight = ((state_q == ARB_IDLE) && bus_pend_q) ||
                          (((state_q == ARB_ISSUE) || (state_q == ARB_WAIT)) &&
                           (src_q == SRC_BUS));

    assign cache_load = (state_q == ARB_DONE) && (src_q == SRC_BUS) &&
                        !timed_out_q && !bus_stale_q;
    assign cache_inv  = (state_q == ARB_DONE) && cur_we_q;

    // Pending latches: set-on-request is applied last so it wins over a clear.
    always_comb begin
        bus_pend_d = bus_pend_q;
        bus_addr_d = bus_addr_q;
        dl_pend_d  = dl_pend_q;
        dl_addr_d  = dl_addr_q;
        dl_data_d  = dl_data_q;
        sv_pend_d  = sv_pend_q;
        sv_we_d    = sv_we_q;
        sv_addr_d  = sv_addr_q;
        sv_din_d   = sv_din_q;

        if (state_q == ARB_DONE) begin
            unique case (src_q)
                SRC_BUS: if (!bus_stale_q) bus_pend_d = 1'b0;
                SRC_DL:  dl_pend_d = 1'b0;
                SRC_SV:  sv_pend_d = 1'b0;
                default: ;
            endcase
        end

        // A hit answers the newest bus request, superseding any pending one.
        if (bus_req) begin
            bus_pend_d = !cache_hit;
            if (!cache_hit) bus_addr_d = bus_addr;
        end
        if (dl_wr && !dl_pend_q) begin
            dl_pend_d = 1'b1;
            dl_addr_d = dl_addr;
            dl_data_d = dl_data;
        end
        if (sv_req && !sv_pend_q) begin
            sv_pend_d = 1'b1;
            sv_we_d   = sv_we;
            sv_addr_d = sv_addr;
            sv_din_d  = sv_din;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        cnt_d       = cnt_q;
        cur_we_d    = cur_we_q;
        cur_addr_d  = cur_addr_q;
        cur_din_d   = cur_din_q;
        rd_data_d   = rd_data_q;
        timed_out_d = timed_out_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (bus_pend_q) begin
                    state_d    = ARB_ISSUE;
                    src_d      = SRC_BUS;
                    cur_we_d   = 1'b0;
                    cur_addr_d = bus_addr_q;
                    cur_din_d  = 8'h00;
                end else if (dl_pend_q) begin
                    state_d    = ARB_ISSUE;
                    src_d      = SRC_DL;
                    cur_we_d   = 1'b1;
                    cur_addr_d = dl_addr_q;
                    cur_din_d  = dl_data_q;
                end else if (sv_pend_q) begin
                    state_d    = ARB_ISSUE;
                    src_d      = SRC_SV;
                    cur_we_d   = sv_we_q;
                    cur_addr_d = sv_addr_q;
                    cur_din_d  = sv_din_q;
                end
            end
            ARB_ISSUE: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (wait_exit) begin
                    state_d     = ARB_DONE;
                    rd_data_d   = exit_data;
                    timed_out_d = !mem_ack;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Completion outputs are registered off the WAIT exit so they line up
    // with the DONE cycle; cache hits respond on the following cycle.
    always_comb begin
        bus_stale_d = bus_stale_q;
        bus_valid_d = 1'b0;
        bus_data_d  = bus_data_q;
        sv_ack_d    = 1'b0;
        sv_dout_d   = sv_dout_q;

        if (state_q == ARB_DONE) bus_stale_d = 1'b0;
        if (bus_req && bus_inflight) bus_stale_d = 1'b1;

        if (bus_req && cache_hit) begin
            bus_valid_d = 1'b1;
            bus_data_d  = cache_data;
        end else if (wait_exit && (src_q == SRC_BUS) && !bus_stale_q && !bus_req) begin
            bus_valid_d = 1'b1;
            bus_data_d  = exit_data;
        end

        if (wait_exit && (src_q == SRC_SV)) begin
            sv_ack_d = 1'b1;
            if (!cur_we_q) sv_dout_d = exit_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            src_q       <= SRC_BUS;
            cnt_q       <= '0;
            bus_pend_q  <= 1'b0;
            bus_addr_q  <= '0;
            dl_pend_q   <= 1'b0;
            dl_addr_q   <= '0;
            dl_data_q   <= '0;
            sv_pend_q   <= 1'b0;
            sv_we_q     <= 1'b0;
            sv_addr_q   <= '0;
            sv_din_q    <= '0;
            cur_we_q    <= 1'b0;
            cur_addr_q  <= '0;
            cur_din_q   <= '0;
            rd_data_q   <= '0;
            timed_out_q <= 1'b0;
            bus_stale_q <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            sv_ack_q    <= 1'b0;
            sv_dout_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            bus_pend_q  <= bus_pend_d;
            bus_addr_q  <= bus_addr_d;
            dl_pend_q   <= dl_pend_d;
            dl_addr_q   <= dl_addr_d;
            dl_data_q   <= dl_data_d;
            sv_pend_q   <= sv_pend_d;
            sv_we_q     <= sv_we_d;
            sv_addr_q   <= sv_addr_d;
            sv_din_q    <= sv_din_d;
            cur_we_q    <= cur_we_d;
            cur_addr_q  <= cur_addr_d;
            cur_din_q   <= cur_din_d;
            rd_data_q   <= rd_data_d;
            timed_out_q <= timed_out_d;
            bus_stale_q <= bus_stale_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            sv_ack_q    <= sv_ack_d;
            sv_dout_q   <= sv_dout_d;
        end
    end

    assign mem_req   = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
    assign mem_we    = cur_we_q;
    assign mem_addr  = cur_addr_q;
    assign mem_din   = cur_din_q;
    assign dl_wait   = dl_pend_q;
    assign bus_valid = bus_valid_q;
    assign bus_data  = bus_data_q;
    assign sv_ack    = sv_ack_q;
    assign sv_dout   = sv_dout_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: stimulus pushes expected memory
// operations and completions; the memory model and a negedge monitor pop them.
module tb_cart_mem_arbiter;

    localparam int unsigned ADDR_W  = 25;
    localparam int unsigned TIMEOUT = 63;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_data;
    logic              bus_valid;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wait;
    logic              sv_req;
    logic              sv_we;
    logic [ADDR_W-1:0] sv_addr;
    logic [7:0]        sv_din;
    logic [7:0]        sv_dout;
    logic              sv_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ack;

    cart_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_wait   (dl_wait),
        .sv_req    (sv_req),
        .sv_we     (sv_we),
        .sv_addr   (sv_addr),
        .sv_din    (sv_din),
        .sv_dout   (sv_dout),
        .sv_ack    (sv_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_ack   (mem_ack)
    );

    initial forever #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0] data;
        int         cyc;      // -1: cycle not checked
    } bus_exp_t;
    typedef struct {
        logic [7:0] data;
        bit         chk;
    } sv_exp_t;
    typedef struct {
        bit              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]      din;
        bit              is_dl;
    } op_exp_t;

    bus_exp_t bus_q[$];
    sv_exp_t  sv_q[$];
    op_exp_t  op_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Memory model state
    logic [7:0]        mem_model [logic [ADDR_W-1:0]];
    int                ack_delay = 4;   // 0: never ack
    int                inject_at = -1;  // cycle of an unsolicited mem_ack
    bit                m_active  = 1'b0;
    int                m_cnt;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_din;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] model_rd(logic [ADDR_W-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a[7:0] ^ 8'h3C;
    endfunction

    // Memory model: counts cycles from the first cycle mem_req is seen high.
    initial begin
        mem_ack  = 1'b0;
        mem_dout = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_ack = 1'b0;
            if (cyc == inject_at) begin
                mem_ack  = 1'b1;
                mem_dout = 8'hEE;
            end
            if (m_active) begin
                if (!mem_req) begin
                    m_active = 1'b0;
                end else begin
                    m_cnt++;
                    if (ack_delay != 0 && m_cnt == ack_delay) begin
                        if (m_we) mem_model[m_addr] = m_din;
                        else mem_dout = model_rd(m_addr);
                        mem_ack  = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end else if (mem_req && !reset) begin
                op_exp_t e;
                m_active = 1'b1;
                m_cnt    = 0;
                m_we     = mem_we;
                m_addr   = mem_addr;
                m_din    = mem_din;
                check("mem_op_expected", 32'(op_q.size() > 0), 32'd1);
                if (op_q.size() > 0) begin
                    e = op_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) check("mem_din", 32'(mem_din), 32'(e.din));
                    if (e.is_dl) check("dl_wait_during_dl_op", 32'(dl_wait), 32'd1);
                end
            end
        end
    end

    // Completion monitor
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset && bus_valid) begin
                bus_exp_t e;
                check("bus_valid_expected", 32'(bus_q.size() > 0), 32'd1);
                if (bus_q.size() > 0) begin
                    e = bus_q.pop_front();
                    check("bus_data", 32'(bus_data), 32'(e.data));
                    if (e.cyc >= 0) check("bus_valid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (!reset && sv_ack) begin
                sv_exp_t s;
                check("sv_ack_expected", 32'(sv_q.size() > 0), 32'd1);
                check("sv_ack_after_bus", 32'(bus_q.size()), 32'd0);
                if (sv_q.size() > 0) begin
                    s = sv_q.pop_front();
                    if (s.chk) check("sv_dout", 32'(sv_dout), 32'(s.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
        bus_req = 1'b0;
        dl_wr   = 1'b0;
        sv_req  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((bus_q.size() != 0 || sv_q.size() != 0 || op_q.size() != 0 ||
                mem_req || m_active) && n < 200) begin
            step();
            n++;
        end
        check({name, "_drained"}, 32'(n < 200), 32'd1);
        repeat (3) step();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 32'({mem_req, mem_we, bus_valid, sv_ack, dl_wait}), 32'd0);
        check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({name, "_data"}, 32'({mem_din, bus_data, sv_dout}), 32'd0);
    endtask

    initial begin
        int t;
        reset    = 1'b1;
        bus_req  = 1'b0;
        bus_addr = '0;
        dl_wr    = 1'b0;
        dl_addr  = '0;
        dl_data  = '0;
        sv_req   = 1'b0;
        sv_we    = 1'b0;
        sv_addr  = '0;
        sv_din   = '0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // 1: cold miss, 4-cycle memory
        t = cyc; bus_req = 1'b1; bus_addr = 25'h01234;
        op_q.push_back('{1'b0, 25'h01234, 8'h00, 1'b0});
        bus_q.push_back('{8'h08, t + 7});
        step();
        check("t1_mem_req_t1", 32'(mem_req), 32'd0);
        step();
        check("t1_mem_req_t2", 32'(mem_req), 32'd1);
        drain("t1");

        // 2: repeat read hits the cache
        t = cyc; bus_req = 1'b1; bus_addr = 25'h01234;
        bus_q.push_back('{8'h08, t + 1});
        step();
        check("t2_no_mem_req", 32'(mem_req), 32'd0);
        drain("t2");

        // 3: simultaneous requests, order bus, dl, sv; sv reads the dl byte
        bus_req = 1'b1; bus_addr = 25'h00100;
        dl_wr   = 1'b1; dl_addr  = 25'h00200; dl_data = 8'hC3;
        sv_req  = 1'b1; sv_we    = 1'b0; sv_addr = 25'h00200;
        op_q.push_back('{1'b0, 25'h00100, 8'h00, 1'b0});
        op_q.push_back('{1'b1, 25'h00200, 8'hC3, 1'b1});
        op_q.push_back('{1'b0, 25'h00200, 8'h00, 1'b0});
        bus_q.push_back('{8'h3C, -1});
        sv_q.push_back('{8'hC3, 1'b1});
        step();
        check("t3_dl_wait_set", 32'(dl_wait), 32'd1);
        drain("t3");
        check("t3_dl_wait_clear", 32'(dl_wait), 32'd0);

        // 4: sv write to the cached address invalidates the entry
        t = cyc; bus_req = 1'b1; bus_addr = 25'h01234;
        op_q.push_back('{1'b0, 25'h01234, 8'h00, 1'b0});
        bus_q.push_back('{8'h08, t + 7});
        step();
        drain("t4a");
        sv_req = 1'b1; sv_we = 1'b1; sv_addr = 25'h01234; sv_din = 8'h5A;
        op_q.push_back('{1'b1, 25'h01234, 8'h5A, 1'b0});
        sv_q.push_back('{8'h00, 1'b0});
        step();
        drain("t4b");
        t = cyc; bus_req = 1'b1; bus_addr = 25'h01234;
        op_q.push_back('{1'b0, 25'h01234, 8'h00, 1'b0});
        bus_q.push_back('{8'h5A, t + 7});
        step();
        drain("t4c");

        // 5: no ack -> fill byte after TIMEOUT+1 cycles of mem_req, no cache load
        ack_delay = 0;
        t = cyc; bus_req = 1'b1; bus_addr = 25'h00777;
        op_q.push_back('{1'b0, 25'h00777, 8'h00, 1'b0});
        bus_q.push_back('{8'hFF, t + 3 + TIMEOUT});
        for (int i = 0; i < 2 + TIMEOUT; i++) step();
        check("t5_mem_req_held", 32'(mem_req), 32'd1);
        step();
        check("t5_mem_req_dropped", 32'(mem_req), 32'd0);
        drain("t5a");
        ack_delay = 4;
        t = cyc; bus_req = 1'b1; bus_addr = 25'h00777;
        op_q.push_back('{1'b0, 25'h00777, 8'h00, 1'b0});
        bus_q.push_back('{8'h4B, t + 7});
        step();
        drain("t5b");

        // 7: address overwritten during WAIT -> one bus_valid for the new address
        bus_req = 1'b1; bus_addr = 25'h00311;
        op_q.push_back('{1'b0, 25'h00311, 8'h00, 1'b0});
        repeat (4) step();
        bus_req = 1'b1; bus_addr = 25'h00355;
        op_q.push_back('{1'b0, 25'h00355, 8'h00, 1'b0});
        bus_q.push_back('{8'h69, -1});
        step();
        drain("t7");

        // 6: reset in WAIT, late ack discarded, cache cleared
        ack_delay = 0;
        bus_req = 1'b1; bus_addr = 25'h00999;
        op_q.push_back('{1'b0, 25'h00999, 8'h00, 1'b0});
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        inject_at = cyc + 2;
        check_all_zero("t6_after_reset");
        repeat (4) step();
        check_all_zero("t6_after_late_ack");
        ack_delay = 4;
        t = cyc; bus_req = 1'b1; bus_addr = 25'h01234;
        op_q.push_back('{1'b0, 25'h01234, 8'h00, 1'b0});
        bus_q.push_back('{8'h5A, t + 7});
        step();
        drain("t6");

        check("final_queues_empty", 32'(bus_q.size() + sv_q.size() + op_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
